// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 pins, deserialises
// 11-bit device-to-host frames, folds E0/F0 prefixes into flags and strobes one
// decoded key event per valid frame on the system clock domain.
module ps2_keyb_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 56000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       kb_valid,
  output logic       rx_error,
  output logic       busy
);

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned FLT_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_REL = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic                 clk_meta;
  logic                 clk_sync;
  logic                 data_meta;
  logic                 data_sync;
  logic                 filt_clk;
  logic                 filt_clk_prev;
  logic [FLT_W-1:0]     flt_cnt;

  logic [FRAME_LEN-1:0] shift_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 ext_q;
  logic                 rel_q;

  logic                 fall_c;
  logic                 tmo_hit_c;
  logic                 start_c;
  logic                 shift_en_c;
  logic                 frame_ok_c;
  logic [7:0]           byte_c;
  logic                 err_c;
  logic                 emit_c;
  logic                 set_ext_c;
  logic                 set_rel_c;

  // Two-flop synchronisers for both asynchronous pins, idle-high on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= clkps2;
      clk_sync  <= clk_meta;
      data_meta <= dataps2;
      data_sync <= data_meta;
    end
  end

  // Clock deglitch: follow the synchronised clock only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk      <= 1'b1;
      filt_clk_prev <= 1'b1;
      flt_cnt       <= '0;
    end else begin
      filt_clk_prev <= filt_clk;
      if (clk_sync == filt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign fall_c    = filt_clk_prev & ~filt_clk;
  // A fall in the same cycle as expiry counts as activity, so the frame survives
  assign tmo_hit_c = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !fall_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fall_c && !data_sync) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (tmo_hit_c) begin
          state_d = IDLE;
        end else if (fall_c && (bit_cnt == CNT_W'(FRAME_LEN - 1))) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output/decode logic: frame validation and event classification per state
  always_comb begin
    start_c    = 1'b0;
    shift_en_c = 1'b0;
    err_c      = 1'b0;
    emit_c     = 1'b0;
    set_ext_c  = 1'b0;
    set_rel_c  = 1'b0;
    byte_c     = shift_q[8:1];
    frame_ok_c = !shift_q[0] && shift_q[FRAME_LEN-1] && (^shift_q[9:1]);
    case (state_q)
      IDLE: begin
        start_c    = fall_c && !data_sync;
        shift_en_c = start_c;
      end
      RECV: begin
        shift_en_c = fall_c;
        err_c      = tmo_hit_c;
      end
      CHECK: begin
        if (!frame_ok_c) begin
          err_c = 1'b1;
        end else if (byte_c == PREFIX_EXT) begin
          set_ext_c = 1'b1;
        end else if (byte_c == PREFIX_REL) begin
          set_rel_c = 1'b1;
        end else begin
          emit_c = 1'b1;
        end
      end
      default: begin
        err_c = 1'b0;
      end
    endcase
  end

  // Frame datapath: LSB-first shift register, bit counter and inter-edge timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (shift_en_c) begin
        shift_q <= {data_sync, shift_q[FRAME_LEN-1:1]};
      end
      if (start_c) begin
        bit_cnt <= CNT_W'(1);
      end else if (state_q == RECV && fall_c) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (state_q != RECV) begin
        bit_cnt <= '0;
      end
      if (state_q == RECV && !fall_c) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  // Prefix flags: set by E0/F0, cleared by any emitted key or any error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (err_c || emit_c) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      if (set_ext_c) begin
        ext_q <= 1'b1;
      end
      if (set_rel_c) begin
        rel_q <= 1'b1;
      end
    end
  end

  // Registered port outputs; the key fields hold until the next emitted event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scancode <= '0;
      extended <= 1'b0;
      released <= 1'b0;
      kb_valid <= 1'b0;
      rx_error <= 1'b0;
      busy     <= 1'b0;
    end else begin
      kb_valid <= emit_c;
      rx_error <= err_c;
      busy     <= (state_d != IDLE);
      if (emit_c) begin
        scancode <= byte_c;
        extended <= ext_q;
        released <= rel_q;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyb_rx.sv
// Randomised and directed bench for ps2_keyb_rx against a frame-level event model.
module tb_ps2_keyb_rx;

  localparam int unsigned FLT = 8;
  localparam int unsigned TMO = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clkps2 = 1'b1;
  logic       dataps2 = 1'b1;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       kb_valid;
  logic       rx_error;
  logic       busy;

  ps2_keyb_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clkps2   (clkps2),
    .dataps2  (dataps2),
    .scancode (scancode),
    .extended (extended),
    .released (released),
    .kb_valid (kb_valid),
    .rx_error (rx_error),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] sc;
    bit         ext;
    bit         rel;
  } ev_t;

  ev_t        q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         err_cyc = -1;
  int         last_fall = 0;
  bit         m_ext = 1'b0;
  bit         m_rel = 1'b0;
  logic [7:0] h_sc = 8'h00;
  bit         h_ext = 1'b0;
  bit         h_rel = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle check of strobes against the expected event queue
  task automatic cmp_cycle();
    ev_t e;
    if (!rst_n) begin
      chk("reset_outputs", {scancode, extended, released, kb_valid, rx_error, busy}, 32'd0);
      h_sc  = 8'h00;
      h_ext = 1'b0;
      h_rel = 1'b0;
    end else if (kb_valid || rx_error) begin
      chk("strobes_exclusive", 32'(kb_valid & rx_error), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, kb_valid, rx_error}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", 32'(rx_error), 32'(e.is_err));
        if (rx_error) err_cyc = cyc;
        if (!e.is_err) begin
          chk("scancode", 32'(scancode), 32'(e.sc));
          chk("extended", 32'(extended), 32'(e.ext));
          chk("released", 32'(released), 32'(e.rel));
          h_sc  = e.sc;
          h_ext = e.ext;
          h_rel = e.rel;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    cmp_cycle();
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Frame-level model: what a complete frame must produce
  task automatic model_frame(input logic [7:0] b, input bit corrupt);
    ev_t e;
    if (corrupt) begin
      e = '{is_err: 1'b1, sc: 8'h00, ext: 1'b0, rel: 1'b0};
      q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      e = '{is_err: 1'b0, sc: b, ext: m_ext, rel: m_rel};
      q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  // Drive nbits of a device-to-host frame with half period hp clk cycles
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int hp, input int nbits);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = (~^b) ^ bad_par;
    f[10]   = ~bad_stop;
    if (nbits == 11) model_frame(b, bad_par | bad_stop);
    for (int i = 0; i < nbits; i++) begin
      dataps2 = f[i];
      wait_n(hp);
      clkps2    = 1'b0;
      last_fall = cyc;
      if (i == 0) begin
        wait_n(FLT + 6);
        chk("busy_in_frame", 32'(busy), 32'd1);
        wait_n(hp - int'(FLT) - 6);
      end else begin
        wait_n(hp);
      end
      clkps2 = 1'b1;
    end
    dataps2 = 1'b1;
  endtask

  // Wait for all expected events, then check idle and held key fields
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
    wait_n(5);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("held_scancode", 32'(scancode), 32'(h_sc));
    chk("held_extended", 32'(extended), 32'(h_ext));
    chk("held_released", 32'(released), 32'(h_rel));
  endtask

  task automatic key(input logic [7:0] b, input int hp);
    send_frame(b, 1'b0, 1'b0, hp, 11);
    drain();
  endtask

  task automatic glitches(input int count);
    for (int k = 0; k < count; k++) begin
      dataps2 = 1'b0;
      clkps2  = 1'b0;
      wait_n(4);
      clkps2  = 1'b1;
      wait_n(20);
      dataps2 = 1'b1;
      wait_n(5);
    end
  endtask

  initial begin
    ev_t        e;
    int         pre;
    int         hp;
    int         n;
    logic [7:0] rb;
    bit         bp;
    bit         bs;

    wait_n(5);
    rst_n = 1'b1;
    wait_n(30);
    chk("post_reset_idle", {24'd0, scancode}, 32'd0);

    // Plain make code
    key(8'h1C, 40);
    chk("lit_1c_sc", 32'(scancode), 32'h1C);
    chk("lit_1c_flags", {30'd0, extended, released}, 32'd0);

    // Break code
    key(8'hF0, 40);
    key(8'h1C, 40);
    chk("lit_f0_1c", {22'd0, scancode, extended, released}, {22'd0, 8'h1C, 1'b0, 1'b1});

    // Extended break, both prefix orders, then plain
    key(8'hE0, 40);
    key(8'hF0, 40);
    key(8'h75, 40);
    chk("lit_e0f0_75", {22'd0, scancode, extended, released}, {22'd0, 8'h75, 1'b1, 1'b1});
    key(8'hF0, 40);
    key(8'hE0, 40);
    key(8'hE0, 40);
    key(8'h75, 40);
    key(8'h75, 40);
    chk("lit_plain_75", {22'd0, scancode, extended, released}, {22'd0, 8'h75, 1'b0, 1'b0});

    // Parity error keeps the last scancode; stop error clears a pending F0
    send_frame(8'h1C, 1'b1, 1'b0, 40, 11);
    drain();
    chk("lit_par_err_hold", 32'(scancode), 32'h75);
    key(8'hF0, 40);
    send_frame(8'h33, 1'b0, 1'b1, 40, 11);
    drain();
    key(8'h1C, 40);
    chk("lit_stop_err_clr", {22'd0, scancode, extended, released}, {22'd0, 8'h1C, 1'b0, 1'b0});

    // Timeout after 5 bits with a pending F0
    key(8'hF0, 40);
    e = '{is_err: 1'b1, sc: 8'h00, ext: 1'b0, rel: 1'b0};
    q.push_back(e);
    m_ext = 1'b0;
    m_rel = 1'b0;
    err_cyc = -1;
    send_frame(8'h5A, 1'b0, 1'b0, 40, 5);
    n = 0;
    while (q.size() != 0 && n < int'(TMO) + 200) begin
      step();
      n++;
    end
    chk("timeout_seen", 32'(q.size()), 32'd0);
    chk("timeout_latency_window",
        32'((err_cyc - last_fall >= int'(TMO)) && (err_cyc - last_fall <= int'(TMO + FLT + 8))), 32'd1);
    wait_n(TMO);
    chk("timeout_busy", 32'(busy), 32'd0);
    key(8'h29, 40);
    chk("lit_after_tmo", {22'd0, scancode, extended, released}, {22'd0, 8'h29, 1'b0, 1'b0});

    // Short clock glitches while idle must not start a frame
    glitches(5);
    chk("glitch_busy", 32'(busy), 32'd0);
    drain();

    // Reset in the middle of a frame with a pending F0
    key(8'hF0, 40);
    send_frame(8'h33, 1'b0, 1'b0, 40, 6);
    rst_n = 1'b0;
    wait_n(3);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    clkps2  = 1'b1;
    dataps2 = 1'b1;
    q.delete();
    m_ext = 1'b0;
    m_rel = 1'b0;
    wait_n(10);
    rst_n = 1'b1;
    wait_n(20);
    key(8'h1C, 40);
    chk("lit_after_rst", {22'd0, scancode, extended, released}, {22'd0, 8'h1C, 1'b0, 1'b0});

    // Randomised traffic
    for (int r = 0; r < 10; r++) begin
      pre = int'($urandom_range(0, 3));
      hp  = int'($urandom_range(25, 45));
      rb  = 8'($urandom_range(0, 255));
      bp  = ($urandom_range(0, 9) == 0);
      bs  = ($urandom_range(0, 9) == 0);
      if (pre == 1 || pre == 3) key(8'hE0, hp);
      if (pre == 2 || pre == 3) key(8'hF0, hp);
      send_frame(rb, bp, bs, hp, 11);
      drain();
      if ($urandom_range(0, 2) == 0) glitches(1);
      wait_n(int'($urandom_range(0, 100)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
